// File: rtl/gate_exerciser.sv
// Gate exerciser: applies all four {a,b} vectors to an external 2-input gate
// and reports per-vector mismatches against the selected expected function.
module gate_exerciser #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op_sel,
    output logic       a_out,
    output logic       b_out,
    input  logic       result_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    // state    | meaning
    // S_IDLE   | waiting for start; results of last run held
    // S_SETTLE | vector applied, settle down-counter running
    // S_CHECK  | compare result_in with expected function
    // S_DONE   | one-cycle done pulse, pass already valid
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_op;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fail;

    logic       w_expect;
    logic       w_mismatch;
    logic [2:0] w_err_next;

    always_comb begin
        w_expect = 1'b0;
        case (r_op)
            2'b00:   w_expect = r_idx[1] & r_idx[0];
            2'b01:   w_expect = r_idx[1] | r_idx[0];
            2'b10:   w_expect = r_idx[1] ^ r_idx[0];
            default: w_expect = ~(r_idx[1] & r_idx[0]);
        endcase
    end

    assign w_mismatch = (r_state == S_CHECK) && (result_in != w_expect);
    assign w_err_next = r_err + {2'b00, w_mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_idx   <= 2'b00;
            r_cnt   <= 4'd0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_fail  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op_sel;
                        r_err   <= 3'd0;
                        r_fail  <= 4'd0;
                        r_pass  <= 1'b0;
                        r_idx   <= 2'b00;
                        r_cnt   <= SETTLE_LOAD;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch) begin
                        r_fail[r_idx] <= 1'b1;
                    end
                    if (r_idx == 2'd3) begin
                        // pass must include this final comparison
                        r_pass  <= (w_err_next == 3'd0);
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_cnt   <= SETTLE_LOAD;
                        r_state <= S_SETTLE;
                    end
                end
                default: begin
                    r_idx   <= 2'b00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // a/b come straight from the index register, so they return to 0 with it
    assign a_out     = r_idx[1];
    assign b_out     = r_idx[0];
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_exerciser.sv
// Self-checking bench for gate_exerciser: vector table, randomized runs
// against an outcome model, and hand-written timing/reset sequences.
module tb_gate_exerciser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [1:0] op_sel = 2'b00;
    logic [1:0] op_sel1 = 2'b00;
    logic [2:0] gate_sel = 3'd0;
    logic [2:0] gate_sel1 = 3'd0;

    logic       a_out, b_out, result_in, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    logic       a_out1, b_out1, result_in1, busy1, done1, pass1;
    logic [2:0] err_count1;
    logic [3:0] fail_vec1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // gate codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 stuck-0, 5 stuck-1
    function automatic logic gate_f(input logic [2:0] g, input logic a, input logic b);
        case (g)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign result_in  = gate_f(gate_sel, a_out, b_out);
    assign result_in1 = gate_f(gate_sel1, a_out1, b_out1);

    gate_exerciser u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
        .a_out(a_out), .b_out(b_out), .result_in(result_in),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_sel(op_sel1),
        .a_out(a_out1), .b_out(b_out1), .result_in(result_in1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_vec(fail_vec1)
    );

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // Outcome of a whole run: compare expected function with attached gate over all four vectors
    task automatic model(input logic [1:0] op, input logic [2:0] gate,
                         output logic ep, output logic [2:0] ee, output logic [3:0] ef);
        ee = 3'd0;
        ef = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (gate_f({1'b0, op}, i[1], i[0]) != gate_f(gate, i[1], i[0])) begin
                ee = ee + 3'd1;
                ef[i] = 1'b1;
            end
        end
        ep = (ee == 3'd0);
    endtask

    task automatic run_chk(input string tag, input logic [1:0] op, input logic [2:0] gate,
                           input int extra_start_cyc, input logic ep,
                           input logic [2:0] ee, input logic [3:0] ef);
        int cyc;
        int dc0;
        dc0 = done_cnt;
        @(negedge clk);
        op_sel = op; gate_sel = gate; start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_vec0"}, {a_out, b_out}, 0);
        @(negedge clk);
        start = 1'b0;
        op_sel = ~op;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == extra_start_cyc);
            if (cyc == 7) chk({tag, "_vec2"}, {a_out, b_out}, 2);
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, cyc, 13);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_pass"}, pass, ep);
        chk({tag, "_err"}, err_count, ee);
        chk({tag, "_failvec"}, fail_vec, ef);
        chk({tag, "_ab_idle"}, {a_out, b_out}, 0);
        if (extra_start_cyc != 0) begin
            repeat (3) @(posedge clk);
            #1;
            chk({tag, "_no_restart"}, busy, 0);
            chk({tag, "_pass_hold"}, pass, ep);
        end
        chk({tag, "_done_count"}, done_cnt - dc0, 1);
    endtask

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [2:0] gate;
        logic       ep;
        logic [2:0] ee;
        logic [3:0] ef;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int c;
        int dc;
        logic       ep;
        logic [2:0] ee;
        logic [3:0] ef;
        logic [1:0] rop;
        logic [2:0] rgate;

        tbl[0] = '{"and_ok",    2'b00, 3'd0, 1'b1, 3'd0, 4'b0000};
        tbl[1] = '{"and_stuck0",2'b00, 3'd4, 1'b0, 3'd1, 4'b1000};
        tbl[2] = '{"xor_on_and",2'b10, 3'd0, 1'b0, 3'd3, 4'b1110};
        tbl[3] = '{"or_ok",     2'b01, 3'd1, 1'b1, 3'd0, 4'b0000};
        tbl[4] = '{"nand_ok",   2'b11, 3'd3, 1'b1, 3'd0, 4'b0000};
        tbl[5] = '{"nand_on_and",2'b11,3'd0, 1'b0, 3'd4, 4'b1111};
        tbl[6] = '{"or_stuck1", 2'b01, 3'd5, 1'b0, 3'd1, 4'b0001};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_failvec", fail_vec, 0);
        chk("rst_ab", {a_out, b_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            run_chk(tbl[k].nm, tbl[k].op, tbl[k].gate, 0, tbl[k].ep, tbl[k].ee, tbl[k].ef);
        end

        run_chk("start_while_busy", 2'b00, 3'd0, 5, 1'b1, 3'd0, 4'b0000);

        for (int r = 0; r < 10; r++) begin
            rop   = 2'($urandom_range(0, 3));
            rgate = 3'($urandom_range(0, 5));
            model(rop, rgate, ep, ee, ef);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_chk("rand", rop, rgate, 0, ep, ee, ef);
        end

        // Start held high: a new run begins straight from IDLE after DONE
        @(negedge clk);
        op_sel = 2'b00; gate_sel = 3'd4; start = 1'b1;
        c = 0;
        while (!done && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("held_first_done", c, 13);
        @(posedge clk); #1;
        chk("held_idle_gap", busy, 0);
        c = 0;
        while (!done && c < 100) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) begin
                chk("held_restart", busy, 1);
                start = 1'b0;
            end
        end
        chk("held_second_done", c, 13);
        chk("held_err", err_count, 1);

        // Reset in cycle 7 of a run
        @(negedge clk);
        op_sel = 2'b10; gate_sel = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        c = 1;
        @(negedge clk);
        start = 1'b0;
        while (c < 7) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst_mid_pre_err", err_count, 1);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_err", err_count, 0);
        chk("rst_mid_failvec", fail_vec, 0);
        chk("rst_mid_pass", pass, 0);
        chk("rst_mid_ab", {a_out, b_out}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt - dc, 0);
        chk("rst_mid_still_idle", busy, 0);
        run_chk("after_rst", 2'b10, 3'd0, 0, 1'b0, 3'd3, 4'b1110);

        // SETTLE_CYCLES = 1 instance, NAND gate
        @(negedge clk);
        op_sel1 = 2'b11; gate_sel1 = 3'd3; start1 = 1'b1;
        @(posedge clk); #1;
        c = 1;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("s1_done_cycle", c, 9);
        @(posedge clk); #1;
        chk("s1_pass", pass1, 1);
        chk("s1_err", err_count1, 0);
        chk("s1_failvec", fail_vec1, 0);
        chk("s1_idle", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
